// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage <-> HI/LO mul/div engine bus: issue, MTHI/MTLO writes, status and HI/LO readback.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_data, rt_data, mthi, mtlo, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning HI/LO. Operands are reduced to
// magnitudes at issue, WIDTH shift-add / restoring shift-subtract iterations
// run in CALC, and FIXUP applies signs and writes HI/LO.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hilo_muldiv_unit_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_reg;      // |multiplicand| or |dividend|
  logic [WIDTH-1:0]   b_reg;      // |multiplier| or |divisor|
  logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {rem, quotient}
  logic               is_div;
  logic               neg_q;      // negate product / quotient
  logic               neg_r;      // negate remainder (dividend sign)
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;

  // Issue-time magnitudes; the most-negative value maps to itself as unsigned.
  logic             sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign sgn_op = bus.op[0];
  assign rs_neg = sgn_op & bus.rs_data[WIDTH-1];
  assign rt_neg = sgn_op & bus.rt_data[WIDTH-1];
  assign rs_abs = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
  assign rt_abs = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

  // One iteration of each engine, evaluated from the current accumulator.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_next;
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    if (!is_div)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction and divide-by-zero override for the FIXUP write.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, hi_fix, lo_fix;
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    q_fix    = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    r_fix    = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end else if (b_reg == '0) begin
      // Divide by zero: quotient all ones, HI gets the original dividend back.
      hi_fix = neg_r ? (~a_reg + 1'b1) : a_reg;
      lo_fix = '1;
    end else begin
      hi_fix = r_fix;
      lo_fix = q_fix;
    end
  end

  // Control FSM, datapath state and HI/LO with registered busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= rs_abs;
            b_reg  <= rt_abs;
            is_div <= bus.op[1];
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            acc    <= bus.op[1] ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= CALC;
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          hi_r   <= hi_fix;
          lo_r   <= lo_fix;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized bench for hilo_muldiv_unit against a 64-bit arithmetic reference.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return ua * ub;
      2'b01: return 64'(sa * sb);
      2'b10: if (b == 0) return {a, 32'hFFFFFFFF};
             else return {32'(ua % ub), 32'(ua / ub)};
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  task automatic idle_bus();
    bus.start = 0; bus.mthi = 0; bus.mtlo = 0;
  endtask

  // Issue one op; optionally disturb it mid-CALC or pair start with a write.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit wr_with_start);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    int n;
    bit stable, busy_ok;
    exp = model(op, a, b);
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
    bus.mthi = wr_with_start; bus.mtlo = wr_with_start; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    idle_bus();
    bus.op = $urandom; bus.rs_data = $urandom; bus.rt_data = $urandom;
    n = 0; stable = 1; busy_ok = 1;
    do begin
      if (disturb && n == 5) begin
        bus.start = 1; bus.mthi = 1; bus.wdata = 32'h1234;
        bus.op = $urandom; bus.rs_data = $urandom; bus.rt_data = $urandom;
      end else if (disturb && n == 6) idle_bus();
      @(posedge clk); #1;
      n++;
      if (!bus.done) begin
        if (bus.hi !== h0 || bus.lo !== l0) stable = 0;
        if (bus.busy !== 1'b1) busy_ok = 0;
      end
    end while (!bus.done && n < 100);
    idle_bus();
    chk({tag, ".latency"}, 64'(n), 64'd33);
    chk({tag, ".stable"}, {63'd0, stable & busy_ok}, 64'd1);
    chk({tag, ".busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, ".result"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic [1:0] op;
    bit timeout_seen;
    idle_bus();
    bus.op = 0; bus.rs_data = 0; bus.rt_data = 0; bus.wdata = 0;
    #12;
    chk("reset.hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset.busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk); reset_n = 1;

    run_op("multu_ff_2", 2'b00, 32'hFFFFFFFF, 32'h2, 0, 0);
    chk("multu_ff_2.exact", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
    run_op("mult_m3_5", 2'b01, 32'hFFFFFFFD, 32'h5, 0, 0);
    chk("mult_m3_5.exact", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("mult_min_min", 2'b01, 32'h80000000, 32'h80000000, 0, 0);
    chk("mult_min_min.exact", {bus.hi, bus.lo}, 64'h40000000_00000000);
    run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'h2, 0, 0);
    chk("div_m7_2.exact", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 0);
    chk("divu_100_7.exact", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op("divu_by0", 2'b10, 32'd10, 32'd0, 0, 0);
    chk("divu_by0.exact", {bus.hi, bus.lo}, 64'h0000000A_FFFFFFFF);
    run_op("div_by0_neg", 2'b11, 32'hFFFFFF00, 32'd0, 0, 0);
    run_op("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_min_m1.exact", {bus.hi, bus.lo}, 64'h00000000_80000000);
    run_op("disturb", 2'b01, 32'h12345678, 32'hFEDCBA98, 1, 0);
    run_op("start_with_mt", 2'b10, 32'd1000, 32'd33, 0, 1);

    // MTHI then MTLO in IDLE, then both at once
    @(negedge clk); bus.mthi = 1; bus.wdata = 32'hAAAA5555;
    @(negedge clk); bus.mthi = 0; bus.mtlo = 1; bus.wdata = 32'h0F0F0F0F;
    @(negedge clk); idle_bus();
    chk("mt.hilo", {bus.hi, bus.lo}, 64'hAAAA5555_0F0F0F0F);
    @(negedge clk); bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h13579BDF;
    @(negedge clk); idle_bus();
    chk("mt.both", {bus.hi, bus.lo}, 64'h13579BDF_13579BDF);

    // Randomized ops, with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      op = 2'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 20);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a MULT
    @(negedge clk);
    bus.start = 1; bus.op = 2'b01; bus.rs_data = 32'h7; bus.rt_data = 32'h9;
    @(negedge clk); idle_bus();
    repeat (9) @(negedge clk);
    reset_n = 0; #1;
    chk("midreset.hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midreset.busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk); reset_n = 1;
    timeout_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) timeout_seen = 1;
    end
    chk("midreset.no_done", {63'd0, timeout_seen}, 64'd0);
    run_op("post_reset", 2'b11, 32'hFFFFFF9C, 32'd7, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
